alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer sitting upstream of the combinational 32-bit ALU (4-bit select, Out, Is0 flag).
- Accepts decoded MIPS instruction fields over a valid/ready handshake, derives the ALU select and operands, and registers the result.
- Sequences multi-step ops the ALU cannot do natively: NOR as OR then NOT, and SLL as repeated ADD.
- Resolves BEQ/BNE from the zero flag and presents result/branch over a downstream valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width; must match the ALU.
- SHAMT_W, 5, shift-amount width.

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- InValid  in  1  upstream instruction valid
- InReady  out  1  block can accept
- Opcode  in  6  instruction opcode
- Funct  in  6  R-type funct
- Shamt  in  SHAMT_W  shift amount
- RsData  in  WIDTH  rs operand
- RtData  in  WIDTH  rt operand
- Imm  in  16  immediate
- AluA  out  WIDTH  ALU operand A
- AluB  out  WIDTH  ALU operand B
- AluSelect  out  4  ALU select
- AluOut  in  WIDTH  ALU result (combinational return)
- AluIs0  in  1  ALU zero flag
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts
- Result  out  WIDTH  registered result
- BranchTaken  out  1  branch resolved taken
- Illegal  out  1  unsupported instruction
- Overflow  out  1  signed overflow (see Optional Feature)

Behaviour:
- Select encoding (fixed): NOT_A=0, AND=1, XOR=2, OR=3, DEC=4, ADD=5, SUB=6, INC=7, SLT=8.
- Decode:
  - Opcode 0x00 by Funct:
    - 0x20/0x21 ADD(rs,rt); 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x2A SLT.
    - 0x27 NOR (two-step).
    - 0x00 SLL (rt shifted left by Shamt; iterative).
  - I-type, B = Imm:
    - 0x08/0x09 ADD sign-extended; 0x0A SLT sign-extended.
    - 0x0C AND, 0x0D OR, 0x0E XOR, all zero-extended.
    - 0x23/0x2B ADD sign-extended (address).
    - 0x04 BEQ and 0x05 BNE: SUB(rs,rt).
  - Anything else: Illegal.
- FSM states IDLE, EXEC, NOT2, ITER, DONE.
  - IDLE: InReady=1. On InValid&&InReady, latch op, operands, Shamt → EXEC. Illegal ops go straight to DONE with Result=0, Illegal=1.
  - EXEC: drive ALU from the latched operands and capture AluOut.
    - Simple ops → DONE.
    - NOR: store OR result → NOT2.
    - SLL with Shamt=0: OR with A=B=rt → DONE.
    - SLL with Shamt≥1: ADD with A=B=rt, cnt=Shamt-1 → ITER if cnt≠0, else DONE.
  - NOT2: NOT_A on the stored value → DONE.
  - ITER: ADD with A=B=acc, acc<=AluOut, cnt--. When cnt reaches 0 → DONE.
  - DONE: OutValid=1; Result, BranchTaken, Illegal, Overflow held stable. On OutReady → IDLE.
- Handshake timing:
  - InReady is 0 in every state except IDLE; no overlap.
  - OutValid never drops without OutReady.
  - If the accept happens at edge N, OutValid rises after:
    - edge N+1 for simple ops and for SLL with Shamt≤1;
    - edge N+2 for NOR;
    - edge N+Shamt for SLL with Shamt≥2;
    - edge N for Illegal.
- BranchTaken: BEQ = AluIs0 captured in EXEC; BNE = !AluIs0. 0 for all non-branch ops. Result for branches = rs-rt.
- Outside EXEC/NOT2/ITER: AluA=AluB=0, AluSelect=ADD.
- Arithmetic wraps modulo 2^WIDTH. SLL with Shamt=31 yields rt<<31.
- Reset (any time, including mid-ITER):
  - State=IDLE.
  - InReady=0 while Rst_n is low, 1 after release.
  - OutValid, Result, BranchTaken, Illegal, Overflow, cnt, acc = 0.
  - In-flight op is discarded.

Optional Feature:
- Macro ALU_ISSUE_OVF_EN.
- Defined:
  - Overflow computed for the signed forms only: Funct 0x20, Funct 0x22, Opcode 0x08.
  - ADD overflow: A[msb]==B[msb] && Out[msb]!=A[msb].
  - SUB overflow: A[msb]!=B[msb] && Out[msb]!=A[msb].
  - Overflow is registered in EXEC. Result still carries the wrapped value.
- Undefined: Overflow tied 0 and no overflow logic is synthesised.

Decomposition:
- Package alu_issue_pkg:
  - Select localparams (NOT_A..SLT).
  - Opcode/Funct constants.
  - FSM state enum.
  - Op-class enum (SIMPLE, NOR, SLL, BRANCH_EQ, BRANCH_NE, ILLEGAL).
- Sub-module alu_issue_decode: purely combinational {Opcode, Funct, Imm} → op class, select, B-source/extension.
- Top holds the FSM, operand/accumulator registers and the handshake.

Test Plan:
- ADD, rs=0x7FFFFFFF, rt=1, OutReady=1 → AluSelect=5 in EXEC; Result=0x80000000; OutValid 1 cycle after accept; Overflow=1 only with ALU_ISSUE_OVF_EN.
- NOR, rs=0x0F0F0000, rt=0x000000F0 → EXEC select 3, NOT2 select 0; Result=0xF0F0FF0F; OutValid 2 cycles after accept.
- SLL Shamt=4, rt=0x00000003 → Result=0x30; 4 cycles; Shamt=0 → Result=rt after 1 cycle; Shamt=31, rt=1 → 0x80000000.
- BEQ rs=rt=5 → BranchTaken=1, Result=0; BNE same operands → BranchTaken=0; ADDI Imm=0xFFFF, rs=1 → Result=0.
- Backpressure: OutReady=0 for 5 cycles → OutValid, Result stable; InReady=0 throughout; Illegal Opcode 0x3F → Illegal=1, Result=0.
- Assert Rst_n low mid-ITER (SLL Shamt=20) → all outputs 0 immediately; after release, state IDLE, InReady=1, next ADD completes correctly.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU select codes, MIPS opcode/funct constants and FSM/op-class types
package alu_issue_pkg;
    localparam logic [3:0] SEL_NOT_A = 4'd0;
    localparam logic [3:0] SEL_AND   = 4'd1;
    localparam logic [3:0] SEL_XOR   = 4'd2;
    localparam logic [3:0] SEL_OR    = 4'd3;
    localparam logic [3:0] SEL_DEC   = 4'd4;
    localparam logic [3:0] SEL_ADD   = 4'd5;
    localparam logic [3:0] SEL_SUB   = 4'd6;
    localparam logic [3:0] SEL_INC   = 4'd7;
    localparam logic [3:0] SEL_SLT   = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_NOT2, S_ITER, S_DONE} state_t;
    typedef enum logic [2:0] {OC_SIMPLE, OC_NOR, OC_SLL, OC_BRANCH_EQ, OC_BRANCH_NE, OC_ILLEGAL} op_class_t;
    typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} b_src_t;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational opcode/funct decode into op class, ALU select and B-operand source
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_t  op_class,
    output logic [3:0] sel,
    output b_src_t     b_src
);
    // map each supported instruction onto a single ALU select; unknown encodings fall to illegal
    always_comb begin
        op_class = OC_ILLEGAL;
        sel = SEL_ADD;
        b_src = B_RT;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: op_class = OC_SIMPLE;
                    F_SUB, F_SUBU: begin op_class = OC_SIMPLE; sel = SEL_SUB; end
                    F_AND: begin op_class = OC_SIMPLE; sel = SEL_AND; end
                    F_OR:  begin op_class = OC_SIMPLE; sel = SEL_OR; end
                    F_XOR: begin op_class = OC_SIMPLE; sel = SEL_XOR; end
                    F_SLT: begin op_class = OC_SIMPLE; sel = SEL_SLT; end
                    F_NOR: begin op_class = OC_NOR; sel = SEL_OR; end
                    F_SLL: op_class = OC_SLL;
                    default: op_class = OC_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin op_class = OC_SIMPLE; b_src = B_SEXT; end
            OP_SLTI: begin op_class = OC_SIMPLE; sel = SEL_SLT; b_src = B_SEXT; end
            OP_ANDI: begin op_class = OC_SIMPLE; sel = SEL_AND; b_src = B_ZEXT; end
            OP_ORI:  begin op_class = OC_SIMPLE; sel = SEL_OR;  b_src = B_ZEXT; end
            OP_XORI: begin op_class = OC_SIMPLE; sel = SEL_XOR; b_src = B_ZEXT; end
            OP_BEQ:  begin op_class = OC_BRANCH_EQ; sel = SEL_SUB; end
            OP_BNE:  begin op_class = OC_BRANCH_NE; sel = SEL_SUB; end
            default: op_class = OC_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage sequencer for the select-driven ALU; define ALU_ISSUE_OVF_EN for the signed overflow flag
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic [WIDTH-1:0]   RsData,
    input  logic [WIDTH-1:0]   RtData,
    input  logic [15:0]        Imm,
    output logic [WIDTH-1:0]   AluA,
    output logic [WIDTH-1:0]   AluB,
    output logic [3:0]         AluSelect,
    input  logic [WIDTH-1:0]   AluOut,
    input  logic               AluIs0,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   Result,
    output logic               BranchTaken,
    output logic               Illegal,
    output logic               Overflow
);
    state_t state, state_nxt;
    op_class_t oc, oc_r;
    b_src_t b_src;
    logic [3:0] sel, sel_r;
    logic [WIDTH-1:0] a_r, b_r, acc, result, b_in;
    logic [SHAMT_W-1:0] cnt;
    logic branch, illegal, accept, busy;

    alu_issue_decode u_decode (
        .opcode(Opcode),
        .funct(Funct),
        .op_class(oc),
        .sel(sel),
        .b_src(b_src)
    );

    assign InReady = Rst_n && state == S_IDLE;
    assign accept = InValid && InReady;
    assign busy = state == S_EXEC || state == S_NOT2 || state == S_ITER;
    assign b_in = b_src == B_SEXT ? {{(WIDTH-16){Imm[15]}}, Imm}
                : b_src == B_ZEXT ? {{(WIDTH-16){1'b0}}, Imm} : RtData;
    assign OutValid = state == S_DONE;
    assign Result = result;
    assign BranchTaken = branch;
    assign Illegal = illegal;

    // next state and ALU drive; SLL doubles rt each step, NOR inverts the stored OR result
    always_comb begin
        state_nxt = state;
        AluA = '0;
        AluB = '0;
        AluSelect = SEL_ADD;
        case (state)
            S_IDLE: if (accept) state_nxt = oc == OC_ILLEGAL ? S_DONE : S_EXEC;
            S_EXEC: begin
                AluA = oc_r == OC_SLL ? b_r : a_r;
                AluB = b_r;
                AluSelect = oc_r != OC_SLL ? sel_r : cnt == '0 ? SEL_OR : SEL_ADD;
                state_nxt = oc_r == OC_NOR ? S_NOT2
                          : (oc_r == OC_SLL && cnt > SHAMT_W'(1)) ? S_ITER : S_DONE;
            end
            S_NOT2: begin
                AluA = acc;
                AluSelect = SEL_NOT_A;
                state_nxt = S_DONE;
            end
            S_ITER: begin
                AluA = acc;
                AluB = acc;
                state_nxt = cnt == SHAMT_W'(1) ? S_DONE : S_ITER;
            end
            S_DONE: if (OutReady) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // state, latched instruction, step counter/accumulator and held result registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
            oc_r <= OC_SIMPLE;
            sel_r <= SEL_ADD;
            a_r <= '0;
            b_r <= '0;
            cnt <= '0;
            acc <= '0;
            result <= '0;
            branch <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                oc_r <= oc;
                sel_r <= sel;
                a_r <= RsData;
                b_r <= b_in;
                cnt <= Shamt;
                result <= '0;
                branch <= 1'b0;
                illegal <= oc == OC_ILLEGAL;
            end
            if (busy) begin
                acc <= AluOut;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
            if (busy && state_nxt == S_DONE) result <= AluOut;
            if (state == S_EXEC) branch <= (oc_r == OC_BRANCH_EQ && AluIs0) || (oc_r == OC_BRANCH_NE && !AluIs0);
        end
    end

`ifdef ALU_ISSUE_OVF_EN
    logic ovf_chk, ovf;

    // flag signed add/sub overflow for the trapping forms only, sampled while EXEC drives the ALU
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ovf_chk <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (accept) begin
                ovf_chk <= (Opcode == OP_RTYPE && (Funct == F_ADD || Funct == F_SUB)) || Opcode == OP_ADDI;
                ovf <= 1'b0;
            end
            if (state == S_EXEC)
                ovf <= ovf_chk && AluOut[WIDTH-1] != AluA[WIDTH-1]
                    && (sel_r == SEL_SUB ? AluA[WIDTH-1] != AluB[WIDTH-1] : AluA[WIDTH-1] == AluB[WIDTH-1]);
        end
    end

    assign Overflow = ovf;
`else
    assign Overflow = 1'b0;
`endif
endmodule
